// File: rtl/spi_master_if.sv
// spi_master_if: byte handshake and SPI pin bundle between the SPI initiator and its user/bus
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       keep_ssel;
    logic       ssel_release;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SSEL;
    modport master (
        input  start, tx_data, keep_ssel, ssel_release, MISO,
        output busy, done, rx_data, SCK, MOSI, SSEL
    );
    modport slave (
        output start, tx_data, keep_ssel, ssel_release, MISO,
        input  busy, done, rx_data, SCK, MOSI, SSEL
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: mode-0 MSB-first 8-bit SPI initiator with start/done handshake and optional SSEL bursts
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_master_if.master   bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] BIT_LO = 3'd2;
    localparam logic [2:0] BIT_HI = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] TAIL   = 3'd5;
    localparam logic [2:0] GAP    = 3'd6;
    localparam int SETUP_N = CS_SETUP * CLK_DIV;
    localparam int DW      = $clog2(SETUP_N + 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic          keep_q, keep_d;
    logic [7:0]    rx_sh_q, rx_q;
    logic [1:0]    miso_q;
    logic          sck_q, mosi_q, ssel_q, done_q, busy_q;
    logic          last, go, byte_end;

    // Next-state logic; new bytes are accepted only in IDLE or HOLD, where busy is low
    always_comb begin
        last     = div_q == DW'((state_q == SETUP ? SETUP_N : CLK_DIV) - 1);
        go       = bus.start && (state_q == IDLE || state_q == HOLD);
        byte_end = state_q == BIT_HI && last && bit_q == 3'd0;
        state_d  = state_q;
        bit_d    = bit_q;
        tx_d     = go ? bus.tx_data : tx_q;
        keep_d   = go ? bus.keep_ssel : keep_q;
        case (state_q)
            IDLE:    if (go) begin state_d = SETUP; bit_d = 3'd7; end
            SETUP:   if (last) state_d = BIT_LO;
            BIT_LO:  if (last) state_d = BIT_HI;
            BIT_HI:  if (last) begin
                         state_d = bit_q != 3'd0 ? BIT_LO : (keep_q ? HOLD : TAIL);
                         bit_d   = bit_q != 3'd0 ? bit_q - 3'd1 : bit_q;
                     end
            HOLD:    if (go) begin state_d = BIT_LO; bit_d = 3'd7; end
                     else if (bus.ssel_release) state_d = TAIL;
            TAIL:    if (last) state_d = GAP;
            GAP:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered pins; pins are decoded from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 8'd0;
            keep_q  <= 1'b0;
            rx_sh_q <= 8'd0;
            rx_q    <= 8'd0;
            miso_q  <= 2'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ssel_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= state_d != state_q ? '0 : div_q + 1'b1;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            keep_q  <= keep_d;
            miso_q  <= {miso_q[0], bus.MISO};
            if (state_q == BIT_HI && last) rx_sh_q <= {rx_sh_q[6:0], miso_q[1]};
            if (byte_end) rx_q <= {rx_sh_q[6:0], miso_q[1]};
            done_q  <= byte_end;
            sck_q   <= state_d == BIT_HI;
            ssel_q  <= state_d == IDLE || state_d == GAP;
            mosi_q  <= (state_d == IDLE || state_d == GAP) ? 1'b0 : tx_d[bit_d];
            busy_q  <= !(state_d == IDLE || state_d == HOLD);
        end
    end

    assign bus.SCK     = sck_q;
    assign bus.MOSI    = mosi_q;
    assign bus.SSEL    = ssel_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.rx_data = rx_q;
endmodule
